// File: rtl/dot_prod_accum.sv
// dot_prod_accum: sums LENGTH accepted complex product beats per window and presents the sum on a valid/ready output
module dot_prod_accum #(
  parameter int I_BITS     = 16,
  parameter int Q_BITS     = 16,
  parameter int LENGTH     = 64,
  parameter int CNT_BITS   = 7,
  parameter int SUM_I_BITS = I_BITS + CNT_BITS,
  parameter int SUM_Q_BITS = Q_BITS + CNT_BITS
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  m_axis_product_tvalid,
  output logic                  s_axis_product_tready,
  input  logic [I_BITS-1:0]     i,
  input  logic [Q_BITS-1:0]     q,
  output logic                  s_axis_sum_tvalid,
  input  logic                  m_axis_sum_tready,
  output logic [SUM_I_BITS-1:0] sum_i,
  output logic [SUM_Q_BITS-1:0] sum_q
);
  typedef enum logic {ACCUM, OUTPUT} state_t;
  state_t state, state_nxt;
  logic [CNT_BITS-1:0] count;
  logic [SUM_I_BITS-1:0] acc_i, add_i;
  logic [SUM_Q_BITS-1:0] acc_q, add_q;
  logic beat, last, take;
  assign s_axis_product_tready = n_reset && state == ACCUM;
  assign beat = m_axis_product_tvalid && s_axis_product_tready;
  assign last = count == CNT_BITS'(LENGTH - 1);
  assign take = s_axis_sum_tvalid && m_axis_sum_tready;
  assign add_i = acc_i + {{(SUM_I_BITS - I_BITS){i[I_BITS-1]}}, i};
  assign add_q = acc_q + {{(SUM_Q_BITS - Q_BITS){q[Q_BITS-1]}}, q};
  always_comb begin
    state_nxt = state;
    if (state == ACCUM) state_nxt = beat && last ? OUTPUT : ACCUM;
    else state_nxt = take ? ACCUM : OUTPUT;
  end
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state             <= ACCUM;
      count             <= '0;
      acc_i             <= '0;
      acc_q             <= '0;
      sum_i             <= '0;
      sum_q             <= '0;
      s_axis_sum_tvalid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) s_axis_sum_tvalid <= 1'b0;
      if (beat && last) begin
        sum_i             <= add_i;
        sum_q             <= add_q;
        acc_i             <= '0;
        acc_q             <= '0;
        count             <= '0;
        s_axis_sum_tvalid <= 1'b1;
      end else if (beat) begin
        acc_i <= add_i;
        acc_q <= add_q;
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dot_prod_accum.sv
// tb_dot_prod_accum: directed vectors for dot_prod_accum with LENGTH=4 and 8-bit products
module tb_dot_prod_accum;
  localparam int I_BITS = 8, Q_BITS = 8, LENGTH = 4, CNT_BITS = 3;
  localparam int SUM_I_BITS = I_BITS + CNT_BITS, SUM_Q_BITS = Q_BITS + CNT_BITS;
  logic clk = 1'b0, n_reset = 1'b0, m_axis_product_tvalid = 1'b0, m_axis_sum_tready = 1'b1;
  logic s_axis_product_tready, s_axis_sum_tvalid;
  logic [I_BITS-1:0] i = '0;
  logic [Q_BITS-1:0] q = '0;
  logic [SUM_I_BITS-1:0] sum_i;
  logic [SUM_Q_BITS-1:0] sum_q;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  dot_prod_accum #(.I_BITS(I_BITS), .Q_BITS(Q_BITS), .LENGTH(LENGTH), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .n_reset(n_reset),
    .m_axis_product_tvalid(m_axis_product_tvalid), .s_axis_product_tready(s_axis_product_tready),
    .i(i), .q(q),
    .s_axis_sum_tvalid(s_axis_sum_tvalid), .m_axis_sum_tready(m_axis_sum_tready),
    .sum_i(sum_i), .sum_q(sum_q)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input int bi, input int bq);
    m_axis_product_tvalid = 1'b1;
    i = I_BITS'(bi);
    q = Q_BITS'(bq);
    step();
    m_axis_product_tvalid = 1'b0;
  endtask
  task automatic idle();
    m_axis_product_tvalid = 1'b0;
    i = 8'd99;
    q = 8'd77;
    step();
  endtask
  task automatic check_sum(input string tag, input int ei, input int eq);
    check({tag, "_valid"}, int'(s_axis_sum_tvalid), 1);
    check({tag, "_i"}, int'($signed(sum_i)), ei);
    check({tag, "_q"}, int'($signed(sum_q)), eq);
  endtask
  initial begin
    step();
    step();
    check("rst_valid", int'(s_axis_sum_tvalid), 0);
    check("rst_tready", int'(s_axis_product_tready), 0);
    check("rst_sum_i", int'($signed(sum_i)), 0);
    n_reset = 1'b1;
    step();
    check("post_rst_tready", int'(s_axis_product_tready), 1);
    beat(1, 2);
    beat(3, -4);
    beat(-5, 6);
    check("basic_not_early", int'(s_axis_sum_tvalid), 0);
    beat(7, 8);
    check_sum("basic", 6, 12);
    check("basic_tready_low", int'(s_axis_product_tready), 0);
    step();
    check("basic_one_cycle", int'(s_axis_sum_tvalid), 0);
    check("basic_tready_back", int'(s_axis_product_tready), 1);
    for (int k = 0; k < 4; k++) beat(-128, 127);
    check_sum("signext", -512, 508);
    step();
    beat(10, -1);
    idle();
    idle();
    beat(20, -2);
    beat(30, -3);
    idle();
    check("gap_not_early", int'(s_axis_sum_tvalid), 0);
    beat(-5, 4);
    check_sum("gap", 55, -2);
    step();
    m_axis_sum_tready = 1'b0;
    beat(1, 1);
    beat(2, 2);
    beat(3, 3);
    beat(4, 4);
    m_axis_product_tvalid = 1'b1;
    i = 8'd100;
    q = -8'sd100;
    for (int k = 0; k < 5; k++) begin
      check_sum("stall", 10, 10);
      check("stall_tready", int'(s_axis_product_tready), 0);
      step();
    end
    m_axis_sum_tready = 1'b1;
    step();
    check("stall_done", int'(s_axis_sum_tvalid), 0);
    check("stall_tready_back", int'(s_axis_product_tready), 1);
    beat(100, -100);
    beat(1, 0);
    beat(1, 0);
    check("held_not_early", int'(s_axis_sum_tvalid), 0);
    beat(1, 0);
    check_sum("held_beat", 103, -100);
    step();
    for (int k = 0; k < 4; k++) beat(1, 1);
    check_sum("b2b_first", 4, 4);
    m_axis_product_tvalid = 1'b1;
    i = 8'd2;
    q = 8'd2;
    step();
    check("b2b_bubble_valid", int'(s_axis_sum_tvalid), 0);
    check("b2b_bubble_tready", int'(s_axis_product_tready), 1);
    for (int k = 0; k < 4; k++) beat(2, 2);
    check_sum("b2b_second", 8, 8);
    step();
    beat(5, 5);
    beat(6, 6);
    n_reset = 1'b0;
    step();
    check("midrst_sum", int'($signed(sum_i)), 0);
    n_reset = 1'b1;
    for (int k = 0; k < 3; k++) beat(1, 1);
    check("midrst_not_early", int'(s_axis_sum_tvalid), 0);
    beat(1, 1);
    check_sum("midrst", 4, 4);
    step();
    m_axis_sum_tready = 1'b0;
    for (int k = 0; k < 4; k++) beat(3, -3);
    check_sum("outrst_pre", 12, -12);
    n_reset = 1'b0;
    step();
    check("outrst_valid", int'(s_axis_sum_tvalid), 0);
    n_reset = 1'b1;
    m_axis_sum_tready = 1'b1;
    step();
    check("outrst_tready", int'(s_axis_product_tready), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dot_prod_accum.md
Name: dot_prod_accum

Overview:
- Downstream stage of the pipelined complex dot-product block (dot_prod_pip).
- Consumes its per-beat complex product stream (i, q) and sums exactly LENGTH accepted beats per window.
- Presents one registered complex window sum on a valid/ready output, then starts the next window.
- Feeds the CAF peak-search / magnitude stage.

Parameters:
- I_BITS, 16, width of signed input product real part.
- Q_BITS, 16, width of signed input product imaginary part.
- LENGTH, 64, beats per accumulation window (>=1).
- CNT_BITS, 7, beat counter width; must satisfy 2**CNT_BITS > LENGTH.
- SUM_I_BITS, I_BITS+CNT_BITS, output real width; must be >= I_BITS+clog2(LENGTH) so the sum cannot overflow.
- SUM_Q_BITS, Q_BITS+CNT_BITS, output imaginary width; same rule as SUM_I_BITS.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  synchronous active-low reset.
- m_axis_product_tvalid  in  1  upstream product beat valid.
- s_axis_product_tready  out  1  this block can accept a product beat.
- i  in  I_BITS  signed product real part.
- q  in  Q_BITS  signed product imaginary part.
- s_axis_sum_tvalid  out  1  window sum valid.
- m_axis_sum_tready  in  1  downstream accepts the sum.
- sum_i  out  SUM_I_BITS  signed accumulated real part.
- sum_q  out  SUM_Q_BITS  signed accumulated imaginary part.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-low (n_reset sampled on rising clk). Reset overrides all other activity.
- Reset values: state=ACCUM, count=0, acc_i=acc_q=0, sum_i=sum_q=0, s_axis_sum_tvalid=0.
- s_axis_product_tready: combinational function of state; 1 in ACCUM, 0 in OUTPUT. It is 0 while n_reset is low.
- Beat acceptance: a beat is accepted on a rising edge when m_axis_product_tvalid && s_axis_product_tready. Non-accepted cycles leave acc and count unchanged, so tvalid gaps are tolerated.
- Sign extension: i and q are sign-extended to SUM_I_BITS / SUM_Q_BITS before adding. Arithmetic is two's complement.
- State ACCUM, accepted beat with count < LENGTH-1: acc += extended input; count++.
- State ACCUM, accepted beat with count == LENGTH-1:
  - sum_i <= acc_i + ext(i); sum_q <= acc_q + ext(q).
  - acc <= 0; count <= 0.
  - s_axis_sum_tvalid <= 1; next state OUTPUT.
- Latency: s_axis_sum_tvalid rises on the edge that accepts the last beat, i.e. it is visible the cycle after that beat was presented.
- LENGTH=1: every accepted beat goes straight to OUTPUT with sum = ext(beat).
- State OUTPUT:
  - sum_i, sum_q and s_axis_sum_tvalid are held stable while m_axis_sum_tready=0.
  - On s_axis_sum_tvalid && m_axis_sum_tready: s_axis_sum_tvalid <= 0; next state ACCUM.
  - s_axis_product_tready is 1 in the following cycle.
  - sum_i/sum_q keep their last value after the handshake and are only meaningful while valid.
- Product beats presented during OUTPUT are not accepted; the upstream stage holds them per valid/ready rules.
- Reset mid-window discards the partial accumulation. Reset during OUTPUT drops the pending sum (tvalid=0 on the next cycle).
- No overflow is possible given the width rules. Count never exceeds LENGTH-1.

Test Plan:
- LENGTH=4, I_BITS=Q_BITS=8; beats (1,2),(3,-4),(-5,6),(7,8) back-to-back, tready=1 -> sum_i=6, sum_q=12; s_axis_sum_tvalid high exactly 1 cycle, the cycle after the 4th beat.
- LENGTH=4, 8-bit; four beats (-128,127) -> sum_i=-512, sum_q=508 at 11-bit output; checks sign extension and no overflow.
- Beats with tvalid gaps (valid 1,0,0,1,1,0,1) -> sum equals the four valid beats only; count unaffected by idle cycles.
- m_axis_sum_tready held 0 for 5 cycles after valid -> sum and tvalid stable, s_axis_product_tready=0 throughout; a beat offered meanwhile is accepted only after the handshake and lands in the next window.
- Two windows back-to-back with tready=1 -> second sum contains no residue of the first; one bubble cycle between windows.
- n_reset=0 for one cycle after 2 of 4 beats, then 4 beats of (1,1) -> sum_i=4, sum_q=4.
